// File: rtl/control_sequencer.sv
// Control sequencer: fetch/exec1/exec2/halt FSM, opcode decode into datapath strobes, return-address stack.
// Optional build macro STACK_TRAP_EN: stack overflow/underflow halts the core instead of continuing.
module control_sequencer #(
  parameter int OP_W        = 4,
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OP_W-1:0]   inst,
  input  logic              eq,
  input  logic [ADDR_W-1:0] pc_value,
  output logic [2:0]        state,
  output logic              ir_load,
  output logic              pc_inc,
  output logic              pc_load,
  output logic              stack_mux,
  output logic [ADDR_W-1:0] ret_addr,
  output logic              acc_load,
  output logic              e,
  output logic              f,
  output logic              wr_en,
  output logic              halted,
  output logic              stack_err
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    ST_HALT  = 3'b000,
    ST_FETCH = 3'b001,
    ST_EXEC1 = 3'b010,
    ST_EXEC2 = 3'b100
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [SP_W-1:0]   sp_r;
  logic [ADDR_W-1:0] stack_r [STACK_DEPTH];
  logic              stack_err_r;

  logic              op_ok_s;
  logic [3:0]        op_s;
  logic              is_sta_s, is_jmp_s, is_jeq_s, is_stp_s;
  logic              is_lda_s, is_jms_s, is_bbl_s, is_ldr_s;
  logic              taken_s, push_s, pop_s;
  logic              sp_full_s, sp_empty_s;
  logic              overflow_s, underflow_s, fault_s;
  logic [IDX_W-1:0]  top_idx_s, push_idx_s;

  // Upper opcode bits, when present, force a NOP.
  generate
    if (OP_W > 4) begin : g_wide_op
      assign op_ok_s = ~|inst[OP_W-1:4];
    end else begin : g_narrow_op
      assign op_ok_s = 1'b1;
    end
  endgenerate

  assign op_s = inst[3:0];

  // Opcode decode.
  always_comb begin
    is_sta_s = 1'b0;
    is_jmp_s = 1'b0;
    is_jeq_s = 1'b0;
    is_stp_s = 1'b0;
    is_lda_s = 1'b0;
    is_jms_s = 1'b0;
    is_bbl_s = 1'b0;
    is_ldr_s = 1'b0;
    case ({op_ok_s, op_s})
      5'b1_0000:            is_sta_s = 1'b1;
      5'b1_0001:            is_jmp_s = 1'b1;
      5'b1_0010, 5'b1_0011: is_jeq_s = 1'b1;
      5'b1_0100:            is_stp_s = 1'b1;
      5'b1_0101:            is_lda_s = 1'b1;
      5'b1_0110:            is_jms_s = 1'b1;
      5'b1_0111:            is_bbl_s = 1'b1;
      5'b1_1110:            is_ldr_s = 1'b1;
      default:              is_sta_s = 1'b0;
    endcase
  end

  assign taken_s     = is_jmp_s | (is_jeq_s & ~eq) | is_jms_s | is_bbl_s;
  assign sp_full_s   = (sp_r == SP_W'(STACK_DEPTH));
  assign sp_empty_s  = (sp_r == {SP_W{1'b0}});
  assign top_idx_s   = IDX_W'(sp_r - SP_W'(1));
  assign push_idx_s  = IDX_W'(sp_r);
  assign push_s      = (state_r == ST_EXEC1) & is_jms_s;
  assign pop_s       = (state_r == ST_EXEC1) & is_bbl_s;
  assign overflow_s  = push_s & sp_full_s;
  assign underflow_s = pop_s & sp_empty_s;

`ifdef STACK_TRAP_EN
  assign fault_s = overflow_s | underflow_s;
`else
  assign fault_s = 1'b0;
`endif

  // Top-of-stack view; an empty stack reads as address zero.
  always_comb begin
    if (sp_empty_s) begin
      ret_addr = {ADDR_W{1'b0}};
    end else begin
      ret_addr = stack_r[top_idx_s];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and per-state strobes.
  always_comb begin
    state_nxt_s = state_r;
    ir_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    acc_load    = 1'b0;
    wr_en       = 1'b0;
    case (state_r)
      ST_FETCH: begin
        ir_load     = 1'b1;
        pc_inc      = 1'b1;
        state_nxt_s = ST_EXEC1;
      end
      ST_EXEC1: begin
        pc_load = taken_s & ~fault_s;
        wr_en   = is_sta_s;
        if (is_stp_s | fault_s) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_EXEC2;
        end
      end
      ST_EXEC2: begin
        acc_load    = is_lda_s | is_ldr_s;
        pc_inc      = ~taken_s;
        state_nxt_s = ST_FETCH;
      end
      ST_HALT:  state_nxt_s = ST_HALT;
      default:  state_nxt_s = ST_FETCH;
    endcase
  end

  // Decode-only selects follow the opcode in every running state.
  always_comb begin
    if (state_r != ST_HALT) begin
      e         = is_lda_s | is_ldr_s;
      stack_mux = is_bbl_s;
    end else begin
      e         = 1'b0;
      stack_mux = 1'b0;
    end
  end

  assign f         = pc_load;
  assign state     = state_r;
  assign halted    = (state_r == ST_HALT);
  assign stack_err = stack_err_r;

  // Return stack: push on JMS, pop on BBL, both at the edge ending EXEC1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_r        <= {SP_W{1'b0}};
      stack_err_r <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_r[i] <= {ADDR_W{1'b0}};
      end
    end else begin
      if (overflow_s | underflow_s) begin
        stack_err_r <= 1'b1;
      end
      if (push_s && !sp_full_s) begin
        stack_r[push_idx_s] <= pc_value;
        sp_r                <= sp_r + SP_W'(1);
`ifndef STACK_TRAP_EN
      end else if (overflow_s) begin
        stack_r[top_idx_s] <= pc_value;
`endif
      end else if (pop_s && !sp_empty_s) begin
        sp_r <= sp_r - SP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer against an instruction-level reference model.
module tb_control_sequencer;

  localparam int OP_W  = 5;
  localparam int AW    = 8;
  localparam int DEPTH = 4;
`ifdef STACK_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clk, reset, eq;
  logic [OP_W-1:0] inst;
  logic [AW-1:0] pc_value, ret_addr;
  logic [2:0]    state;
  logic ir_load, pc_inc, pc_load, stack_mux, acc_load, e, f, wr_en, halted, stack_err;

  control_sequencer #(.OP_W(OP_W), .ADDR_W(AW), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .inst(inst), .eq(eq), .pc_value(pc_value),
    .state(state), .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load),
    .stack_mux(stack_mux), .ret_addr(ret_addr), .acc_load(acc_load), .e(e),
    .f(f), .wr_en(wr_en), .halted(halted), .stack_err(stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase within instruction, halt flag, stack as a queue.
  int           m_ph;
  bit           m_halt;
  bit           m_err;
  logic [AW-1:0] m_stk[$];

  localparam logic [OP_W-1:0] OP_STA = 5'h00, OP_JMP = 5'h01, OP_JEQ = 5'h02,
                              OP_STP = 5'h04, OP_LDA = 5'h05, OP_JMS = 5'h06,
                              OP_BBL = 5'h07, OP_LDR = 5'h0E, OP_NOP = 5'h09;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_halt = 1'b0; m_err = 1'b0;
    m_stk.delete();
  endtask

  task automatic decode(input logic [OP_W-1:0] op, output bit sta, output bit jmp, output bit jeq,
                        output bit stp, output bit lda, output bit jms, output bit bbl, output bit ldr);
    int v;
    v = (op < 16) ? int'(op) : -1;
    sta = (v == 0);  jmp = (v == 1); jeq = (v == 2) || (v == 3); stp = (v == 4);
    lda = (v == 5);  jms = (v == 6); bbl = (v == 7);             ldr = (v == 14);
  endtask

  task automatic check_outputs();
    bit sta, jmp, jeq, stp, lda, jms, bbl, ldr, taken, fault;
    logic [2:0] x_state;
    bit x_ir, x_inc, x_load, x_acc, x_wr, x_e, x_mux;
    logic [AW-1:0] x_ret;
    decode(inst, sta, jmp, jeq, stp, lda, jms, bbl, ldr);
    taken = jmp || (jeq && !eq) || jms || bbl;
    fault = TRAP && ((jms && m_stk.size() == DEPTH) || (bbl && m_stk.size() == 0));
    x_ret = (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : '0;
    {x_ir, x_inc, x_load, x_acc, x_wr, x_e, x_mux} = '0;
    x_state = 3'b000;
    if (!m_halt) begin
      x_e = lda || ldr;
      x_mux = bbl;
      x_state = 3'(1 << m_ph);
      if (m_ph == 0) begin x_ir = 1; x_inc = 1; end
      if (m_ph == 1) begin x_load = taken && !fault; x_wr = sta; end
      if (m_ph == 2) begin x_acc = lda || ldr; x_inc = !taken; end
    end
    check_val("state", 32'(state), 32'(x_state));
    check_val("ir_load", 32'(ir_load), 32'(x_ir));
    check_val("pc_inc", 32'(pc_inc), 32'(x_inc));
    check_val("pc_load", 32'(pc_load), 32'(x_load));
    check_val("f", 32'(f), 32'(x_load));
    check_val("acc_load", 32'(acc_load), 32'(x_acc));
    check_val("wr_en", 32'(wr_en), 32'(x_wr));
    check_val("e", 32'(e), 32'(x_e));
    check_val("stack_mux", 32'(stack_mux), 32'(x_mux));
    check_val("ret_addr", 32'(ret_addr), 32'(x_ret));
    check_val("halted", 32'(halted), 32'(m_halt));
    check_val("stack_err", 32'(stack_err), 32'(m_err));
  endtask

  // Advance the model across one clock edge with the inputs that were applied.
  task automatic step_model();
    bit sta, jmp, jeq, stp, lda, jms, bbl, ldr;
    decode(inst, sta, jmp, jeq, stp, lda, jms, bbl, ldr);
    if (m_halt) return;
    if (m_ph == 0) m_ph = 1;
    else if (m_ph == 2) m_ph = 0;
    else begin
      m_ph = 2;
      if (stp) m_halt = 1;
      if (jms) begin
        if (m_stk.size() < DEPTH) m_stk.push_back(pc_value);
        else begin
          m_err = 1;
          if (TRAP) m_halt = 1;
          else m_stk[DEPTH-1] = pc_value;
        end
      end
      if (bbl) begin
        if (m_stk.size() > 0) void'(m_stk.pop_back());
        else begin
          m_err = 1;
          if (TRAP) m_halt = 1;
        end
      end
    end
  endtask

  // Called just after a rising edge: drive, check on the falling edge, step the model.
  task automatic do_cycle(input logic [OP_W-1:0] op, input logic eqv, input logic [AW-1:0] pcv);
    inst = op; eq = eqv; pc_value = pcv;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
    step_model();
  endtask

  task automatic do_instr(input logic [OP_W-1:0] op, input logic eqv, input logic [AW-1:0] pcv);
    for (int i = 0; i < 3; i++) do_cycle(op, eqv, pcv);
  endtask

  // Asynchronous reset pulse raised between clock edges.
  task automatic reset_pulse();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [OP_W-1:0] cur_op;
    int halt_cnt;
    reset = 1'b1; inst = OP_NOP; eq = 1'b0; pc_value = '0;
    model_reset();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // NOP stream and conditional branches on both eq values
    do_instr(OP_NOP, 1'b0, 8'h00);
    do_instr(5'h1A, 1'b0, 8'h00);
    do_instr(OP_JEQ, 1'b0, 8'h00);
    do_instr(5'h03, 1'b1, 8'h00);
    do_instr(OP_JMP, 1'b1, 8'h00);
    // Nested call/return, then underflow
    do_instr(OP_JMS, 1'b0, 8'h12);
    do_instr(OP_JMS, 1'b0, 8'h34);
    do_instr(OP_BBL, 1'b0, 8'h00);
    do_instr(OP_BBL, 1'b0, 8'h00);
    do_instr(OP_BBL, 1'b0, 8'h00);
    reset_pulse();
    // Overflow on the fifth push
    for (int i = 0; i < 6; i++) do_instr(OP_JMS, 1'b0, 8'(8'h40 + i));
    do_instr(OP_BBL, 1'b0, 8'h00);
    reset_pulse();
    // Store/load, then stop and stay halted
    do_instr(OP_STA, 1'b0, 8'h00);
    do_instr(OP_LDA, 1'b0, 8'h00);
    do_instr(OP_LDR, 1'b0, 8'h00);
    do_instr(OP_STP, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) do_cycle(OP_NOP, 1'b0, 8'h00);
    reset_pulse();
    // Reset in the middle of a store with a populated stack
    do_instr(OP_JMS, 1'b0, 8'h77);
    do_cycle(OP_STA, 1'b0, 8'h00);
    inst = OP_STA;
    #1;
    check_val("wr_en_pre_reset", 32'(wr_en), 32'(1));
    reset_pulse();

    cur_op = OP_NOP;
    halt_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (m_halt) begin
        halt_cnt++;
        if (halt_cnt > 4) begin
          reset_pulse();
          halt_cnt = 0;
        end
      end
      if (m_ph == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2: cur_op = OP_JMS;
          3, 4:    cur_op = OP_BBL;
          default: cur_op = OP_W'($urandom);
        endcase
      end
      if ($urandom_range(0, 150) == 0) reset_pulse();
      do_cycle(cur_op, 1'($urandom), AW'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
